// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: gated frequency meter with BCD output.
// Counts synchronised rising edges of sig_in over a fixed window of GATE_CYCLES
// clocks, saturates at 10**DIGITS-1, then converts the count to packed BCD
// with a one-bit-per-cycle double-dabble before publishing it on bcd_out.
module freq_meter_bcd #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 20,
  parameter int DIGITS      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_in,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int BIT_W  = $clog2(CNT_W + 1);

  // Gate-counter value of the final cycle of the window.
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  // Largest count that still fits in DIGITS decimal digits.
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(10 ** DIGITS - 1);
  // Bit counter value of the final double-dabble step.
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  // Input synchroniser and edge detector.
  logic                 sync1_r;
  logic                 sync2_r;
  logic                 sync3_r;
  logic                 rise_s;

  // Gate window and edge counting.
  logic [GATE_W-1:0]    gate_cnt_r;
  logic [CNT_W-1:0]     edge_cnt_r;
  logic [CNT_W-1:0]     edge_cnt_nxt_s;
  logic                 ovf_flag_r;
  logic                 ovf_nxt_s;

  // Sequencing strobes decoded from the current state.
  logic                 gate_clr_s;
  logic                 gate_run_s;
  logic                 conv_load_s;
  logic                 conv_step_s;
  logic                 conv_last_s;

  // Shift-add converter.
  logic [CNT_W-1:0]     conv_bin_r;
  logic [BCD_W-1:0]     conv_bcd_r;
  logic [BCD_W-1:0]     conv_step_val_s;
  logic [BIT_W-1:0]     bit_cnt_r;

  // One double-dabble step: add 3 to every nibble that is 5 or more, then
  // shift the whole BCD vector left and bring in the next binary bit.  The
  // top bit shifted out is always zero because the count never exceeds
  // MAX_CNT.
  function automatic logic [BCD_W-1:0] dabble_step(
    input logic [BCD_W-1:0] bcd,
    input logic             bit_in
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = bcd[4*d +: 4];
      end
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // sig_in is asynchronous: two flops for metastability, a third for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~sync3_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; dropping en aborts any measurement in progress.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_nxt_s = GATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt_s = IDLE;
        end else if (gate_cnt_r == GATE_LAST) begin
          state_nxt_s = CONVERT;
        end else begin
          state_nxt_s = GATE;
        end
      end
      CONVERT: begin
        if (!en) begin
          state_nxt_s = IDLE;
        end else if (bit_cnt_r == LAST_BIT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CONVERT;
        end
      end
      DONE: begin
        if (en) begin
          state_nxt_s = GATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM output decode: datapath strobes for the current state.
  always_comb begin
    gate_clr_s  = 1'b0;
    gate_run_s  = 1'b0;
    conv_load_s = 1'b0;
    conv_step_s = 1'b0;
    conv_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        gate_clr_s = en;
      end
      GATE: begin
        gate_run_s  = 1'b1;
        conv_load_s = en && (gate_cnt_r == GATE_LAST);
      end
      CONVERT: begin
        conv_step_s = en;
        conv_last_s = en && (bit_cnt_r == LAST_BIT);
      end
      DONE: begin
        gate_clr_s = en;
      end
      default: begin
        gate_clr_s = 1'b0;
      end
    endcase
  end

  // Next edge count: cleared at gate start, incremented on a rise, held at MAX_CNT.
  always_comb begin
    edge_cnt_nxt_s = edge_cnt_r;
    ovf_nxt_s      = ovf_flag_r;
    if (gate_clr_s) begin
      edge_cnt_nxt_s = {CNT_W{1'b0}};
      ovf_nxt_s      = 1'b0;
    end else if (gate_run_s && rise_s) begin
      if (edge_cnt_r >= MAX_CNT) begin
        edge_cnt_nxt_s = MAX_CNT;
        ovf_nxt_s      = 1'b1;
      end else begin
        edge_cnt_nxt_s = edge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_nxt_s      = ovf_flag_r;
      end
    end else begin
      edge_cnt_nxt_s = edge_cnt_r;
      ovf_nxt_s      = ovf_flag_r;
    end
  end

  // Gate window counter and edge counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      edge_cnt_r <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
    end else begin
      if (gate_clr_s) begin
        gate_cnt_r <= {GATE_W{1'b0}};
      end else if (gate_run_s) begin
        gate_cnt_r <= gate_cnt_r + {{(GATE_W-1){1'b0}}, 1'b1};
      end else begin
        gate_cnt_r <= gate_cnt_r;
      end
      edge_cnt_r <= edge_cnt_nxt_s;
      ovf_flag_r <= ovf_nxt_s;
    end
  end

  assign conv_step_val_s = dabble_step(conv_bcd_r, conv_bin_r[CNT_W-1]);

  // Double-dabble converter; loads from the next-count so a rise in the last gate cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_bin_r <= {CNT_W{1'b0}};
      conv_bcd_r <= {BCD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
    end else begin
      if (conv_load_s) begin
        conv_bin_r <= edge_cnt_nxt_s;
        conv_bcd_r <= {BCD_W{1'b0}};
        bit_cnt_r  <= {BIT_W{1'b0}};
      end else if (conv_step_s) begin
        conv_bin_r <= {conv_bin_r[CNT_W-2:0], 1'b0};
        conv_bcd_r <= conv_step_val_s;
        bit_cnt_r  <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
      end else begin
        conv_bin_r <= conv_bin_r;
        conv_bcd_r <= conv_bcd_r;
        bit_cnt_r  <= bit_cnt_r;
      end
    end
  end

  // Result registers: updated only on entry to DONE so they coincide with the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out  <= {BCD_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (conv_last_s) begin
        bcd_out  <= conv_step_val_s;
        overflow <= ovf_flag_r;
      end else begin
        bcd_out  <= bcd_out;
        overflow <= overflow;
      end
    end
  end

  // Status outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      busy  <= (state_nxt_s == GATE) || (state_nxt_s == CONVERT);
      valid <= (state_nxt_s == DONE);
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// tb_freq_meter_bcd: scoreboard bench for freq_meter_bcd with a short gate.
// Expected results are queued before each measurement; a negedge monitor
// pops one per valid pulse and compares it against bcd_out/overflow.
module tb_freq_meter_bcd;

  localparam int G      = 1000;
  localparam int CNT_W  = 20;
  localparam int DIGITS = 6;
  localparam int PERIOD = G + CNT_W + 1;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sig_in = 1'b0;
  logic        en     = 1'b0;
  logic [23:0] bcd_out;
  logic        valid;
  logic        overflow;
  logic        busy;

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          sig_half = 0;  // sig_in half period in ns; 0 holds it low
  longint      cyc      = 0;

  freq_meter_bcd #(
    .GATE_CYCLES(G),
    .CNT_W      (CNT_W),
    .DIGITS     (DIGITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .en      (en),
    .bcd_out (bcd_out),
    .valid   (valid),
    .overflow(overflow),
    .busy    (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Free-running cycle counter for interval measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave source, edges offset from the clock.
  initial begin
    #3;
    forever begin
      if (sig_half == 0) begin
        sig_in = 1'b0;
        #10;
      end else begin
        #(sig_half) sig_in = ~sig_in;
      end
    end
  end

  function automatic int bcd2bin(input logic [23:0] b);
    int r;
    r = 0;
    for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(b[4*d +: 4]);
    return r;
  endfunction

  function automatic bit nibbles_ok(input logic [23:0] b);
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scoreboard monitor: nibble legality every cycle, result check on each valid.
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (rst_n) begin
      checks++;
      if (!nibbles_ok(bcd_out)) begin
        failures++;
        $display("FAIL nibble_range bcd_out=%h", bcd_out);
      end
      if (valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid bcd_out=%h overflow=%b", bcd_out, overflow);
        end else begin
          e = sb.pop_front();
          v = bcd2bin(bcd_out);
          if (v < e.lo || v > e.hi || overflow !== e.ovf) begin
            failures++;
            $display("FAIL result got=%0d (bcd %h) overflow=%b want=%0d..%0d overflow=%b",
                     v, bcd_out, overflow, e.lo, e.hi, e.ovf);
          end
        end
      end
    end
  end

  task automatic go_idle();
    en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bcd_out !== 24'h000000 || valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values bcd=%h valid=%b ovf=%b busy=%b want 000000/0/0/0",
               bcd_out, valid, overflow, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_zero_hz();
    go_idle();
    sig_half = 0;
    repeat (10) @(negedge clk);
    sb.push_back('{lo: 0, hi: 0, ovf: 1'b0});
    en = 1'b1;
    for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL zero_hz_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
    go_idle();
    sig_half = 20;  // period 4 clk
    repeat (10) @(negedge clk);
    sb.push_back('{lo: 249, hi: 251, ovf: 1'b0});
    en = 1'b1;
    for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL period4_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    longint t[3];
    int     n;
    go_idle();
    sig_half = 50;  // period 10 clk
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) sb.push_back('{lo: 99, hi: 101, ovf: 1'b0});
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (valid !== 1'b1 && n < 2 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid_timeout pulse=%0d waited=%0d", k, n);
      end
      t[k] = cyc;
      if (k == 2) en = 1'b0;
      @(negedge clk);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (t[k] - t[k-1] != longint'(PERIOD)) begin
        failures++;
        $display("FAIL b2b_interval got=%0d want=%0d", t[k] - t[k-1], PERIOD);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_pending got=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_conversion_sweep();
    int          vals[5];
    logic [19:0] fv;
    int          n;
    vals = '{9, 10, 99_999, 123_456, 999_999};
    for (int k = 0; k < 5; k++) begin
      go_idle();
      sig_half = 0;
      repeat (10) @(negedge clk);
      sb.push_back('{lo: vals[k], hi: vals[k], ovf: 1'b0});
      en = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      fv = 20'(vals[k]);
      force dut.edge_cnt_r = fv;
      @(negedge clk);
      release dut.edge_cnt_r;
      for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL sweep_timeout value=%0d pending=%0d", vals[k], sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_abort();
    int n;
    // Prior result is 999999 with overflow clear from the sweep.
    go_idle();
    sig_half = 50;
    repeat (10) @(negedge clk);
    en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (499) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b want=0", busy);
    end
    repeat (PERIOD + 50) @(negedge clk);
    checks++;
    if (bcd_out !== 24'h999999 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold bcd=%h ovf=%b want=999999/0", bcd_out, overflow);
    end
    sb.push_back('{lo: 99, hi: 101, ovf: 1'b0});
    en = 1'b1;
    for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL abort_restart_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_saturation();
    logic [19:0] fv;
    int          n;
    go_idle();
    sig_half = 10;  // period 2 clk
    repeat (10) @(negedge clk);
    sb.push_back('{lo: 999_999, hi: 999_999, ovf: 1'b1});
    en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    fv = 20'd999_990;
    force dut.edge_cnt_r = fv;
    @(negedge clk);
    release dut.edge_cnt_r;
    for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL saturate_timeout pending=%0d", sb.size());
      sb.delete();
    end
    // Next measurement must clear overflow: about 250 rises on top of 499750.
    go_idle();
    sig_half = 20;
    repeat (10) @(negedge clk);
    sb.push_back('{lo: 499_998, hi: 500_002, ovf: 1'b0});
    en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    fv = 20'd499_750;
    force dut.edge_cnt_r = fv;
    @(negedge clk);
    release dut.edge_cnt_r;
    for (int i = 0; i < 3 * PERIOD && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL post_saturate_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_convert();
    int n;
    int cycles;
    go_idle();
    sig_half = 50;
    repeat (10) @(negedge clk);
    sb.push_back('{lo: 99, hi: 101, ovf: 1'b0});
    en = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (G + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 24'h000000 || valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset bcd=%h valid=%b ovf=%b busy=%b want 000000/0/0/0",
               bcd_out, valid, overflow, busy);
    end
    sb.delete();
    @(negedge clk);
    sb.push_back('{lo: 99, hi: 101, ovf: 1'b0});
    rst_n = 1'b1;
    // The cycle in which rst_n is released counts as the first.
    cycles = 1;
    while (valid !== 1'b1 && cycles < 2 * PERIOD) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != G + CNT_W + 2) begin
      failures++;
      $display("FAIL reset_latency got=%0d want=%0d", cycles, G + CNT_W + 2);
    end
    go_idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_pending got=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_zero_hz();
    test_back_to_back();
    test_conversion_sweep();
    test_abort();
    test_saturation();
    test_reset_mid_convert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
